// File: rtl/vmem_port_responder.sv
// Memory-side responder for the vector load/store port: splits each 128-bit access
// into word beats on a single-port sample RAM and returns assembled load vectors.
module vmem_port_responder #(
  parameter int ADDR_W = 16,
  parameter int VEC_W  = 128,
  parameter int WORD_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  data_b,
  output logic              req_ready,
  output logic              busy,
  output logic              rsp_valid,
  output logic [VEC_W-1:0]  q_b,
  output logic              err_align,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam int BEATS = VEC_W / WORD_W;
  localparam int BW    = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  state_t              state_q;
  logic [BW-1:0]       beat_q;
  logic [BW-1:0]       cap_q;
  logic [VEC_W-1:0]    data_q;
  logic [VEC_W-1:0]    shadow_q;
  logic [VEC_W-1:0]    shadow_d;
  logic [VEC_W-1:0]    q_b_q;
  logic [RD_LAT-1:0]   rd_vld_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [WORD_W-1:0]   mem_wdata_q;
  logic                mem_we_q;
  logic                mem_re_q;
  logic                rsp_valid_q;
  logic                err_align_q;
  logic                cap_en;

  // rd_vld_q delays each read strobe by RD_LAT so a capture lines up with its data.
  always_comb begin
    cap_en   = (state_q == READ) && rd_vld_q[RD_LAT-1];
    shadow_d = shadow_q;
    if (cap_en) shadow_d[WORD_W*int'(cap_q) +: WORD_W] = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      cap_q       <= '0;
      data_q      <= '0;
      shadow_q    <= '0;
      q_b_q       <= '0;
      rd_vld_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      err_align_q <= 1'b0;
      shadow_q    <= shadow_d;
      rd_vld_q[0] <= mem_re_q;
      for (int i = 1; i < RD_LAT; i++) rd_vld_q[i] <= rd_vld_q[i-1];
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // Misaligned requests still run, on the enclosing aligned vector.
            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            data_q      <= data_b;
            beat_q      <= '0;
            cap_q       <= '0;
            err_align_q <= (req_addr[1:0] != 2'b00);
            if (req_we) begin
              state_q     <= WRITE;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= data_b[WORD_W-1:0];
            end else begin
              state_q  <= READ;
              mem_re_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (beat_q == LAST) begin
            mem_we_q    <= 1'b0;
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            beat_q      <= beat_q + BW'(1);
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= data_q[WORD_W*(int'(beat_q)+1) +: WORD_W];
          end
        end
        READ: begin
          if (mem_re_q) begin
            if (beat_q == LAST) begin
              mem_re_q <= 1'b0;
            end else begin
              beat_q     <= beat_q + BW'(1);
              mem_addr_q <= mem_addr_q + ADDR_W'(1);
            end
          end
          if (cap_en) begin
            cap_q <= cap_q + BW'(1);
            if (cap_q == LAST) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              q_b_q       <= shadow_d;
            end
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign rsp_valid = rsp_valid_q;
  assign q_b       = q_b_q;
  assign err_align = err_align_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_vmem_port_responder.sv
// Directed bench for vmem_port_responder with a RAM model and expectation queues.
module tb_vmem_port_responder;

  localparam int RD_LAT = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_we;
  logic [15:0]  req_addr;
  logic [127:0] data_b;
  logic         req_ready;
  logic         busy;
  logic         rsp_valid;
  logic [127:0] q_b;
  logic         err_align;
  logic [15:0]  mem_addr;
  logic         mem_we;
  logic         mem_re;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;

  vmem_port_responder #(.ADDR_W(16), .VEC_W(128), .WORD_W(32), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .data_b(data_b), .req_ready(req_ready), .busy(busy),
    .rsp_valid(rsp_valid), .q_b(q_b), .err_align(err_align), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [15:0] a; logic [31:0] d; } wr_t;
  typedef struct { int c; bit ld; logic [127:0] q; } rsp_t;

  wr_t          wq[$];
  logic [15:0]  rq[$];
  rsp_t         rspq[$];
  int           acc_log[$];
  int           checks = 0;
  int           failures = 0;
  int           err_cyc = -1;
  int           busy_from = 0;
  int           busy_to = -1;
  logic [127:0] exp_load = '0;
  logic [127:0] last_q = '0;

  localparam logic [127:0] D1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] D4 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
  localparam logic [127:0] D5 = 128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;
  localparam logic [127:0] DMIX = 128'h00112233_44556677_F0F0F0F0_0F0F0F0F;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor / scoreboard: expectations are queued at acceptance, retired as the DUT acts.
  always @(negedge clk) begin
    if (reset) begin
      if (req_valid && req_ready) begin
        logic [15:0] base;
        rsp_t r;
        base = {req_addr[15:2], 2'b00};
        acc_log.push_back(cyc);
        r.ld = !req_we;
        r.q  = exp_load;
        r.c  = req_we ? cyc + 5 : cyc + 5 + RD_LAT;
        for (int k = 0; k < 4; k++) begin
          wr_t w;
          w.a = base + 16'(k);
          w.d = data_b[32*k +: 32];
          if (req_we) wq.push_back(w);
          else rq.push_back(w.a);
        end
        rspq.push_back(r);
        err_cyc   = (req_addr[1:0] != 2'b00) ? cyc + 1 : -1;
        busy_from = cyc + 1;
        busy_to   = r.c;
      end
      check("we_re_exclusive", 128'(mem_we & mem_re), 128'd0);
      if (mem_we) begin
        check("write_expected", 128'(wq.size() != 0), 128'd1);
        if (wq.size() != 0) begin
          wr_t w;
          w = wq.pop_front();
          check("write_addr", 128'(mem_addr), 128'(w.a));
          check("write_data", 128'(mem_wdata), 128'(w.d));
        end
      end
      if (mem_re) begin
        check("read_expected", 128'(rq.size() != 0), 128'd1);
        if (rq.size() != 0) check("read_addr", 128'(mem_addr), 128'(rq.pop_front()));
      end
      check("err_align", 128'(err_align), 128'(cyc == err_cyc));
      check("busy", 128'(busy), 128'(cyc >= busy_from && cyc <= busy_to));
      check("ready_vs_busy", 128'(req_ready), 128'(!busy));
      check("rsp_valid", 128'(rsp_valid), 128'(rspq.size() != 0 && rspq[0].c == cyc));
      if (rsp_valid && rspq.size() != 0) begin
        rsp_t r;
        r = rspq.pop_front();
        if (r.ld) begin
          check("load_q_b", q_b, r.q);
          last_q = r.q;
        end else begin
          check("store_q_b_held", q_b, last_q);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [15:0] a, input logic [127:0] d,
                      input logic [127:0] eq);
    int n;
    @(posedge clk); #1;
    exp_load = eq; req_valid = 1'b1; req_we = we; req_addr = a; data_b = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("accepted", 128'(req_ready), 128'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (rspq.size() != 0 && n < 200) begin @(posedge clk); n++; end
    check("response_seen", 128'(rspq.size() == 0), 128'd1);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; data_b = '0;
    mem_rdata = '0;
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    #3;
    check("rst_ready", 128'(req_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_rsp", 128'(rsp_valid), 128'd0);
    check("rst_err", 128'(err_align), 128'd0);
    check("rst_strobes", 128'({mem_we, mem_re}), 128'd0);
    check("rst_addr", 128'(mem_addr), 128'd0);
    check("rst_wdata", 128'(mem_wdata), 128'd0);
    check("rst_q_b", q_b, 128'd0);
    @(negedge clk); reset = 1'b1;

    // Store, then read back aligned and misaligned.
    send(1'b1, 16'h0010, D1, '0);
    wait_done();
    check("ram_10", 128'(ram[16'h0010]), 128'hCCDDEEFF);
    check("ram_11", 128'(ram[16'h0011]), 128'h8899AABB);
    check("ram_12", 128'(ram[16'h0012]), 128'h44556677);
    check("ram_13", 128'(ram[16'h0013]), 128'h00112233);
    send(1'b0, 16'h0010, '0, D1);
    wait_done();
    send(1'b0, 16'h0013, '0, D1);
    wait_done();

    // Top of address space.
    send(1'b1, 16'hFFFC, D4, '0);
    wait_done();
    check("ram_fffc", 128'(ram[16'hFFFC]), 128'h12345678);
    check("ram_ffff", 128'(ram[16'hFFFF]), 128'hDEADBEEF);
    send(1'b0, 16'hFFFE, '0, D4);
    wait_done();

    // Reset during beat 2 of a store.
    send(1'b1, 16'h0010, D5, '0);
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("mid_rst_we", 128'(mem_we), 128'd0);
    check("mid_rst_q_b", q_b, 128'd0);
    check("mid_rst_ready", 128'(req_ready), 128'd1);
    check("mid_rst_rsp", 128'(rsp_valid), 128'd0);
    check("partial_beats_left", 128'(wq.size()), 128'd2);
    wq.delete(); rq.delete(); rspq.delete();
    err_cyc = -1; busy_to = -1; last_q = '0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    check("post_rst_ready", 128'(req_ready), 128'd1);
    send(1'b0, 16'h0010, '0, DMIX);
    wait_done();

    // Requester holds req_valid across a whole load.
    acc_log.delete();
    @(posedge clk); #1;
    exp_load = DMIX; req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; data_b = '0;
    begin
      int n;
      n = 0;
      while (acc_log.size() < 2 && n < 100) begin @(posedge clk); n++; end
    end
    #1;
    req_valid = 1'b0;
    check("held_two_accepts", 128'(acc_log.size()), 128'd2);
    if (acc_log.size() >= 2)
      check("held_accept_gap", 128'(acc_log[1] - acc_log[0]), 128'd7);
    wait_done();
    repeat (3) @(posedge clk);
    check("held_no_extra", 128'(acc_log.size()), 128'd2);
    check("writes_drained", 128'(wq.size()), 128'd0);
    check("reads_drained", 128'(rq.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
